adbg_ahb3_biu_burst_ctrl: RTL
=============================

Name: adbg_ahb3_biu_burst_ctrl

Overview:
- Debug-side initiator for the AHB3 BIU handshake (biu_strb/biu_rdy/biu_err). It runs in the TCK/biu_clk domain.
- Accepts one burst command: read or write, start address, word size and count. It issues one BIU strobe per word and increments the address.
- Streams write data in, and read data out, over valid/ready ports.
- Records sticky bus errors together with the failing address. Sits between the debug AHB module command decoder and the AHB BIU.

Parameters:
ADDR_WIDTH, 32, width of cmd_addr, biu_addr and err_addr
DATA_WIDTH, 32, BIU data width; legal values are 32 and 64
CNT_WIDTH, 16, width of the burst word count

Ports:
biu_clk  in  1  clock; all logic is on the rising edge
biu_rst  in  1  reset, asynchronous, active-high
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_rw  in  1  1=read, 0=write (same polarity as biu_rw)
cmd_addr  in  ADDR_WIDTH  start byte address
cmd_word_size  in  4  bytes per word: 1, 2, 4, or 8 (8 legal only when DATA_WIDTH=64)
cmd_count  in  CNT_WIDTH  number of words
wr_valid  in  1  write word available
wr_ready  out  1  write word consumed on wr_valid && wr_ready
wr_data  in  DATA_WIDTH  write word, right-justified
rd_valid  out  1  read word available
rd_ready  in  1  read word taken on rd_valid && rd_ready
rd_data  out  DATA_WIDTH  read word, right-justified
busy  out  1  a burst is in progress
done  out  1  one-cycle pulse at the end of a burst
err  out  1  sticky error flag
err_addr  out  ADDR_WIDTH  address of the first failing or illegal transfer
err_clr  in  1  clears err
biu_strb  out  1  BIU start strobe
biu_rw  out  1  BIU direction, 1=read
biu_addr  out  ADDR_WIDTH  BIU address
biu_di  out  DATA_WIDTH  BIU write data
biu_word_size  out  4  BIU word size
biu_rdy  in  1  BIU ready; drops the cycle after an accepted strobe
biu_err  in  1  BIU bus error; valid when biu_rdy returns high
biu_do  in  DATA_WIDTH  BIU read data, right-justified; valid when biu_rdy returns high

Behaviour:
- Reset values:
  - State IDLE.
  - cmd_ready=1, wr_ready=0, rd_valid=0, rd_data=0.
  - busy=0, done=0, err=0, err_addr=0.
  - biu_strb=0, biu_rw=1, biu_addr=0, biu_di=0, biu_word_size=4.
  - Internal address and counter registers reset to 0.
- Reset asserted mid-burst: return to IDLE immediately with all values above. The BIU transaction in flight is abandoned.
- cmd_ready is combinational: 1 only in IDLE. busy is 1 in every state except IDLE.
- All outputs other than cmd_ready and busy are registered.
- FSM states: IDLE, WDATA, STROBE, WAIT, RHOLD.
- IDLE, on command accept: latch rw, addr, size and count.
  - Illegal size: set err, err_addr=cmd_addr, pulse done next cycle, stay in IDLE.
  - count==0: pulse done next cycle, no strobe, err unchanged.
  - Otherwise: go to WDATA for a write, or STROBE for a read. biu_rw, biu_word_size and biu_addr are loaded.
- WDATA: wr_ready=1.
  - On wr_valid && wr_ready, load biu_di = wr_data << (DATA_WIDTH - 8*size). Example: byte 0xA5 → biu_di=0xA500_0000 for DATA_WIDTH=32.
  - Go to STROBE.
  - wr_ready deasserts in the cycle after the accept.
- STROBE: wait for biu_rdy=1, then drive biu_strb=1 for exactly one cycle and go to WAIT.
  - biu_addr, biu_rw, biu_di and biu_word_size are stable from the cycle before the strobe until the transfer completes.
- WAIT: ignore the first cycle after the strobe (biu_rdy is still low). Complete on the first cycle with biu_rdy=1.
  - biu_err=1:
    - If err=0, capture err_addr=biu_addr.
    - Set err.
    - Abort the remaining burst: no rd_valid, no further wr_ready. Pulse done and go to IDLE.
  - biu_err=0, read: rd_data=biu_do, rd_valid=1, go to RHOLD.
  - biu_err=0, write: decrement count and add size to the address.
    - If count is now 0: pulse done, go to IDLE.
    - Otherwise go to WDATA.
- RHOLD: hold rd_valid until rd_ready. In the accept cycle, decrement count and add size to the address.
  - Count reaches 0: done, then IDLE.
  - Otherwise: STROBE.
  - At most one read word is outstanding; there is no backpressure into the BIU.
- Address arithmetic:
  - Next address = addr + size, modulo 2^ADDR_WIDTH (wraps, e.g. 0xFFFF_FFFC+4 → 0x0000_0000).
  - No alignment check; unaligned addresses pass through.
- done: one-cycle pulse, asserted in the same cycle the FSM re-enters IDLE. A new command can be accepted in that cycle.
- err_clr clears err. If err_clr and a new error occur in the same cycle, the set wins and err_addr is updated.
- Per-word cost at minimum: the strobe cycle + BIU round trip + 1 cycle (write) or + rd handshake (read).

Test Plan:
- Write burst: addr 0x100, size 4, count 3, data 0x11111111/0x22222222/0x33333333, BIU model ready after 4 cycles → 3 strobes at 0x100/0x104/0x108, biu_di matches each word, single done, err=0.
- Read burst of bytes: addr 0x203, size 1, count 2, biu_do=0x5A then 0xC3, rd_ready held low for 5 cycles on the first word → second strobe not issued until the first word is taken; rd_data 0x5A, 0xC3; addresses 0x203, 0x204.
- Error abort: write, count 4, biu_err=1 on the 2nd transfer → err=1, err_addr=start+size, no 3rd strobe, done pulse; err_clr → err=0.
- Boundaries:
  - count=0 → done 1 cycle after accept, no biu_strb.
  - size 3 → err=1, err_addr=cmd_addr.
  - Address 0xFFFF_FFFE, size 2, count 2 → second address 0x0000_0000.
- Reset: assert biu_rst in WAIT during a read → all outputs reach reset values, cmd_ready=1, and a new command is accepted normally after release.

Source files
------------

// File: rtl/adbg_ahb3_biu_burst_ctrl.sv
// Debug-side burst initiator for the AHB3 BIU strobe/ready handshake.
// Issues one BIU strobe per word, streams write/read data over valid/ready and records sticky bus errors.
module adbg_ahb3_biu_burst_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  biu_clk,
  input  logic                  biu_rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_rw,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [3:0]            cmd_word_size,
  input  logic [CNT_WIDTH-1:0]  cmd_count,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] err_addr,
  input  logic                  err_clr,
  output logic                  biu_strb,
  output logic                  biu_rw,
  output logic [ADDR_WIDTH-1:0] biu_addr,
  output logic [DATA_WIDTH-1:0] biu_di,
  output logic [3:0]            biu_word_size,
  input  logic                  biu_rdy,
  input  logic                  biu_err,
  input  logic [DATA_WIDTH-1:0] biu_do
);

  localparam int SHW = $clog2(DATA_WIDTH) + 1;

  typedef enum logic [2:0] {IDLE, WDATA, STROBE, WAIT, RHOLD} state_t;

  state_t                r_state;
  logic [CNT_WIDTH-1:0]  r_count;

  logic                  w_size_ok;
  logic [SHW-1:0]        w_shift;
  logic [ADDR_WIDTH-1:0] w_next_addr;
  logic                  w_last;
  logic                  w_err_capture;

  assign w_size_ok = (cmd_word_size == 4'd1) || (cmd_word_size == 4'd2) ||
                     (cmd_word_size == 4'd4) || ((DATA_WIDTH == 64) && (cmd_word_size == 4'd8));
  assign w_shift       = SHW'(DATA_WIDTH - 8 * int'(biu_word_size));
  assign w_next_addr   = biu_addr + ADDR_WIDTH'(biu_word_size);
  assign w_last        = (r_count == CNT_WIDTH'(1));
  // err_addr keeps the first failure; a clear in the same cycle lets the new failure through.
  assign w_err_capture = !err || err_clr;

  assign cmd_ready = (r_state == IDLE);
  assign busy      = (r_state != IDLE);

  always_ff @(posedge biu_clk or posedge biu_rst) begin
    if (biu_rst) begin
      r_state       <= IDLE;
      r_count       <= '0;
      wr_ready      <= 1'b0;
      rd_valid      <= 1'b0;
      rd_data       <= '0;
      done          <= 1'b0;
      err           <= 1'b0;
      err_addr      <= '0;
      biu_strb      <= 1'b0;
      biu_rw        <= 1'b1;
      biu_addr      <= '0;
      biu_di        <= '0;
      biu_word_size <= 4'd4;
    end else begin
      done     <= 1'b0;
      biu_strb <= 1'b0;
      if (err_clr) err <= 1'b0;

      case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            r_count <= cmd_count;
            if (!w_size_ok) begin
              err  <= 1'b1;
              if (w_err_capture) err_addr <= cmd_addr;
              done <= 1'b1;
            end else if (cmd_count == '0) begin
              done <= 1'b1;
            end else begin
              biu_rw        <= cmd_rw;
              biu_word_size <= cmd_word_size;
              biu_addr      <= cmd_addr;
              if (cmd_rw) begin
                r_state <= STROBE;
              end else begin
                r_state  <= WDATA;
                wr_ready <= 1'b1;
              end
            end
          end
        end

        WDATA: begin
          if (wr_valid && wr_ready) begin
            biu_di   <= wr_data << w_shift;
            wr_ready <= 1'b0;
            r_state  <= STROBE;
          end
        end

        STROBE: begin
          if (biu_rdy) begin
            biu_strb <= 1'b1;
            r_state  <= WAIT;
          end
        end

        // The strobe cycle itself still shows the pre-strobe biu_rdy, so it is skipped.
        WAIT: begin
          if (!biu_strb && biu_rdy) begin
            if (biu_err) begin
              err  <= 1'b1;
              if (w_err_capture) err_addr <= biu_addr;
              done    <= 1'b1;
              r_state <= IDLE;
            end else if (biu_rw) begin
              rd_data  <= biu_do;
              rd_valid <= 1'b1;
              r_state  <= RHOLD;
            end else begin
              r_count  <= r_count - CNT_WIDTH'(1);
              biu_addr <= w_next_addr;
              if (w_last) begin
                done    <= 1'b1;
                r_state <= IDLE;
              end else begin
                wr_ready <= 1'b1;
                r_state  <= WDATA;
              end
            end
          end
        end

        RHOLD: begin
          if (rd_ready) begin
            rd_valid <= 1'b0;
            r_count  <= r_count - CNT_WIDTH'(1);
            biu_addr <= w_next_addr;
            if (w_last) begin
              done    <= 1'b1;
              r_state <= IDLE;
            end else begin
              r_state <= STROBE;
            end
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
